// File: rtl/fft_ctrl_gen.sv
// Radix-2 DIF FFT controller: loads a frame into sample RAM, sequences butterflies with arithmetic
// addressing, then streams results out in bit-reversed order. FFT_CTRL_IFFT_EN adds inverse/conj_F.
module fft_ctrl_gen #(
  parameter int unsigned LOG2N  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BF_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FFT_CTRL_IFFT_EN
  input  logic                  inverse,
  output logic                  conj_F,
`endif
  input  logic                  in_push,
  input  logic [DATA_W-1:0]     in_real,
  input  logic [DATA_W-1:0]     in_imag,
  output logic                  in_stall_F,
  output logic [LOG2N-1:0]      read_addr_1_F,
  output logic [LOG2N-1:0]      read_addr_2_F,
  output logic [LOG2N-2:0]      W_addr_F,
  output logic [LOG2N-1:0]      write_addr_1_F,
  output logic [2*DATA_W-1:0]   write_data_1_F,
  output logic                  write_en_1_F,
  output logic [LOG2N-1:0]      write_addr_2_F,
  output logic                  write_en_2_F,
  output logic                  write_back_F,
  output logic                  out_push_F,
  input  logic                  out_stall,
  output logic                  frame_done_F
);

  localparam int unsigned BubW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [1:0] StRx      = 2'd0;
  localparam logic [1:0] StCompute = 2'd1;
  localparam logic [1:0] StTx      = 2'd2;

  localparam logic [LOG2N-1:0] CntLast   = '1;
  localparam logic [LOG2N-2:0] BflyLast  = '1;
  localparam logic [LOG2N-1:0] One       = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [3:0]       StageLast = 4'(LOG2N-1);
  localparam logic [BubW-1:0]  BubLast   = BubW'(BF_LAT-1);

  logic [1:0]       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [3:0]       stage_q, stage_d;
  logic [LOG2N-2:0] bfly_q, bfly_d;
  logic [BubW-1:0]  bub_q, bub_d;
  logic             in_bub_q, in_bub_d;

  logic             accept, issue;
  logic [LOG2N-1:0] b_ext, half_v, lo_mask, a_v, b_v;
  logic [LOG2N-2:0] w_v;

  // Butterfly operand/valid delay line matching the datapath latency.
  logic [LOG2N-1:0] pipe_a_q [BF_LAT];
  logic [LOG2N-1:0] pipe_b_q [BF_LAT];
  logic [BF_LAT-1:0] pipe_v_q;

  logic                in_stall_d, out_push_d, frame_done_d;
  logic [LOG2N-1:0]    read_addr_1_d, read_addr_2_d, write_addr_1_d, write_addr_2_d;
  logic [LOG2N-2:0]    W_addr_d;
  logic [2*DATA_W-1:0] write_data_1_d;
  logic                write_en_1_d, write_en_2_d, write_back_d;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // A = (b / half) * 2 * half + (b mod half), with half a power of two.
  always_comb begin
    b_ext   = {1'b0, bfly_q};
    half_v  = One << (StageLast - stage_q);
    lo_mask = half_v - One;
    a_v     = ((b_ext & ~lo_mask) << 1) | (b_ext & lo_mask);
    b_v     = a_v | half_v;
    w_v     = (bfly_q & lo_mask[LOG2N-2:0]) << stage_q;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stage_d        = stage_q;
    bfly_d         = bfly_q;
    bub_d          = bub_q;
    in_bub_d       = in_bub_q;
    accept         = 1'b0;
    issue          = 1'b0;
    in_stall_d     = 1'b1;
    read_addr_1_d  = '0;
    read_addr_2_d  = '0;
    W_addr_d       = '0;
    out_push_d     = 1'b0;
    frame_done_d   = 1'b0;
    write_data_1_d = write_data_1_F;
    case (state_q)
      StRx: begin
        in_stall_d = 1'b0;
        if (in_push && !in_stall_F) begin
          accept         = 1'b1;
          cnt_d          = cnt_q + 1'b1;
          write_data_1_d = {in_real, in_imag};
          if (cnt_q == CntLast) begin
            state_d    = StCompute;
            in_stall_d = 1'b1;
            stage_d    = '0;
            bfly_d     = '0;
            bub_d      = '0;
            in_bub_d   = 1'b0;
          end
        end
      end
      StCompute: begin
        if (!in_bub_q) begin
          issue         = 1'b1;
          read_addr_1_d = a_v;
          read_addr_2_d = b_v;
          W_addr_d      = w_v;
          if (bfly_q == BflyLast) begin
            bfly_d   = '0;
            bub_d    = '0;
            in_bub_d = 1'b1;
          end else begin
            bfly_d = bfly_q + 1'b1;
          end
        end else if (bub_q == BubLast) begin
          // Bubbles let the previous stage's results land before they are re-read.
          in_bub_d = 1'b0;
          if (stage_q == StageLast) begin
            state_d = StTx;
            stage_d = '0;
            cnt_d   = '0;
          end else begin
            stage_d = stage_q + 4'd1;
          end
        end else begin
          bub_d = bub_q + 1'b1;
        end
      end
      StTx: begin
        if (!out_stall) begin
          read_addr_1_d = bitrev(cnt_q);
          out_push_d    = 1'b1;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            frame_done_d = 1'b1;
            state_d      = StRx;
            in_stall_d   = 1'b0;
          end
        end
      end
      default: state_d = StRx;
    endcase
  end

  // Input writes and butterfly write-backs never overlap in time.
  always_comb begin
    write_en_1_d   = accept | pipe_v_q[BF_LAT-1];
    write_addr_1_d = accept ? cnt_q : pipe_a_q[BF_LAT-1];
    write_en_2_d   = pipe_v_q[BF_LAT-1];
    write_addr_2_d = pipe_b_q[BF_LAT-1];
    write_back_d   = pipe_v_q[BF_LAT-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v_q <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        pipe_a_q[i] <= '0;
        pipe_b_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0] <= issue;
      pipe_a_q[0] <= a_v;
      pipe_b_q[0] <= b_v;
      for (int i = 1; i < BF_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_a_q[i] <= pipe_a_q[i-1];
        pipe_b_q[i] <= pipe_b_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StRx;
      cnt_q          <= '0;
      stage_q        <= '0;
      bfly_q         <= '0;
      bub_q          <= '0;
      in_bub_q       <= 1'b0;
      in_stall_F     <= 1'b1;
      read_addr_1_F  <= '0;
      read_addr_2_F  <= '0;
      W_addr_F       <= '0;
      write_addr_1_F <= '0;
      write_data_1_F <= '0;
      write_en_1_F   <= 1'b0;
      write_addr_2_F <= '0;
      write_en_2_F   <= 1'b0;
      write_back_F   <= 1'b0;
      out_push_F     <= 1'b0;
      frame_done_F   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stage_q        <= stage_d;
      bfly_q         <= bfly_d;
      bub_q          <= bub_d;
      in_bub_q       <= in_bub_d;
      in_stall_F     <= in_stall_d;
      read_addr_1_F  <= read_addr_1_d;
      read_addr_2_F  <= read_addr_2_d;
      W_addr_F       <= W_addr_d;
      write_addr_1_F <= write_addr_1_d;
      write_data_1_F <= write_data_1_d;
      write_en_1_F   <= write_en_1_d;
      write_addr_2_F <= write_addr_2_d;
      write_en_2_F   <= write_en_2_d;
      write_back_F   <= write_back_d;
      out_push_F     <= out_push_d;
      frame_done_F   <= frame_done_d;
    end
  end

`ifdef FFT_CTRL_IFFT_EN
  logic inv_q, inv_d, conj_d;

  // Direction is latched on the first sample so a frame is never mixed.
  always_comb begin
    inv_d  = (accept && (cnt_q == '0)) ? inverse : inv_q;
    conj_d = (state_d == StCompute) & inv_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_q  <= 1'b0;
      conj_F <= 1'b0;
    end else begin
      inv_q  <= inv_d;
      conj_F <= conj_d;
    end
  end
`endif

endmodule

// File: tb/tb_fft_ctrl_gen.sv
// Bench for fft_ctrl_gen: default 16-point instance plus an 8-point, BF_LAT=2 instance.
`timescale 1ns/1ps
module tb_fft_ctrl_gen;
  localparam int L0 = 4, N0 = 16, LAT0 = 4;
  localparam int L1 = 3, N1 = 8, LAT1 = 2;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic in_push0, out_stall0, in_stall0, we1_0, we2_0, wb_0, op_0, fd_0;
  logic [DW-1:0] in_real0, in_imag0;
  logic [L0-1:0] ra1_0, ra2_0, wa1_0, wa2_0;
  logic [L0-2:0] w_0;
  logic [2*DW-1:0] wd_0;

  logic in_push1, out_stall1, in_stall1, we1_1, we2_1, wb_1, op_1, fd_1;
  logic [DW-1:0] in_real1, in_imag1;
  logic [L1-1:0] ra1_1, ra2_1, wa1_1, wa2_1;
  logic [L1-2:0] w_1;
  logic [2*DW-1:0] wd_1;
`ifdef FFT_CTRL_IFFT_EN
  logic conj0, conj1;
`endif

  fft_ctrl_gen #(.LOG2N(L0), .DATA_W(DW), .BF_LAT(LAT0)) dut0 (
    .clk(clk), .reset(reset),
`ifdef FFT_CTRL_IFFT_EN
    .inverse(1'b0), .conj_F(conj0),
`endif
    .in_push(in_push0), .in_real(in_real0), .in_imag(in_imag0), .in_stall_F(in_stall0),
    .read_addr_1_F(ra1_0), .read_addr_2_F(ra2_0), .W_addr_F(w_0),
    .write_addr_1_F(wa1_0), .write_data_1_F(wd_0), .write_en_1_F(we1_0),
    .write_addr_2_F(wa2_0), .write_en_2_F(we2_0), .write_back_F(wb_0),
    .out_push_F(op_0), .out_stall(out_stall0), .frame_done_F(fd_0)
  );

  fft_ctrl_gen #(.LOG2N(L1), .DATA_W(DW), .BF_LAT(LAT1)) dut1 (
    .clk(clk), .reset(reset),
`ifdef FFT_CTRL_IFFT_EN
    .inverse(1'b0), .conj_F(conj1),
`endif
    .in_push(in_push1), .in_real(in_real1), .in_imag(in_imag1), .in_stall_F(in_stall1),
    .read_addr_1_F(ra1_1), .read_addr_2_F(ra2_1), .W_addr_F(w_1),
    .write_addr_1_F(wa1_1), .write_data_1_F(wd_1), .write_en_1_F(we1_1),
    .write_addr_2_F(wa2_1), .write_en_2_F(we2_1), .write_back_F(wb_1),
    .out_push_F(op_1), .out_stall(out_stall1), .frame_done_F(fd_1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: event seen or timed out (got 1, required 0)", nm);
  endtask

  typedef struct {int s; int b; int a; int bb; int w;} bf_vec_t;
  bf_vec_t vecs[8];
  int tx_order0[16];
  int tx_order1[8];

  // Scoreboards
  int in_qa[$];
  logic [2*DW-1:0] in_qd[$];
  int bf_qa[$];
  int bf_qb[$];
  int out_q0[$];
  int out_q1[$];

  // Per-frame logs indexed by cycles since in_stall_F rose
  int k0 = 1000, k1 = 1000, cyc = 0;
  logic prev0 = 1'b1, prev1 = 1'b1;
  int rd_a0[64], rd_b0[64], rd_w0[64], wr_a0[64], wr_b0[64], wr_e0[64];
  int rd_a1[32], rd_b1[32];
  int n_push0 = 0, n_push1 = 0, first_k0 = -1, first_k1 = -1;
  int push_cyc0[16], push_addr0[16];

  function automatic int exp_a(input int s, input int b, input int n);
    int half;
    half = n >> (s + 1);
    return ((b / half) * 2 * half) + (b % half);
  endfunction

  always @(negedge clk) if (!reset) begin
    cyc++;
    if (in_stall0 && !prev0) k0 = 0; else if (k0 < 100000) k0++;
    prev0 = in_stall0;
    if (k0 < 64) begin
      rd_a0[k0] = int'(ra1_0); rd_b0[k0] = int'(ra2_0); rd_w0[k0] = int'(w_0);
      wr_a0[k0] = int'(wa1_0); wr_b0[k0] = int'(wa2_0);
      wr_e0[k0] = int'(we1_0 & we2_0 & wb_0);
    end
    if (we1_0 && !wb_0) begin
      if (in_qa.size() == 0) flag("in_write_unexpected");
      else begin
        chk("in_write_addr", int'(wa1_0), in_qa.pop_front());
        chk("in_write_data", int'(wd_0), int'(in_qd.pop_front()));
        chk("in_write_en2", int'(we2_0), 0);
      end
    end
    if (we1_0 && wb_0) begin
      if (bf_qa.size() == 0) flag("bf_write_unexpected");
      else begin
        chk("bf_write_a", int'(wa1_0), bf_qa.pop_front());
        chk("bf_write_b", int'(wa2_0), bf_qb.pop_front());
        chk("bf_write_en2", int'(we2_0), 1);
      end
    end
    if (we2_0 && !we1_0) flag("we2_without_we1");
    if (op_0) begin
      if (n_push0 == 0) first_k0 = k0;
      if (n_push0 < 16) begin push_cyc0[n_push0] = cyc; push_addr0[n_push0] = int'(ra1_0); end
      n_push0++;
      if (out_q0.size() == 0) flag("tx_push_unexpected");
      else begin
        chk("tx_addr", int'(ra1_0), out_q0.pop_front());
        chk("tx_addr2", int'(ra2_0), 0);
        chk("tx_frame_done", int'(fd_0), int'(n_push0 == N0));
      end
    end else if (fd_0) flag("frame_done_without_push");
  end

  always @(negedge clk) if (!reset) begin
    if (in_stall1 && !prev1) k1 = 0; else if (k1 < 100000) k1++;
    prev1 = in_stall1;
    if (k1 < 32) begin rd_a1[k1] = int'(ra1_1); rd_b1[k1] = int'(ra2_1); end
    if (op_1) begin
      if (n_push1 == 0) first_k1 = k1;
      n_push1++;
      if (out_q1.size() == 0) flag("tx1_push_unexpected");
      else begin
        chk("tx1_addr", int'(ra1_1), out_q1.pop_front());
        chk("tx1_frame_done", int'(fd_1), int'(n_push1 == N1));
      end
    end
  end

  task automatic send0(input int f, input int extra);
    for (int s = 0; s < L0; s++)
      for (int b = 0; b < N0 / 2; b++) begin
        bf_qa.push_back(exp_a(s, b, N0));
        bf_qb.push_back(exp_a(s, b, N0) + (N0 >> (s + 1)));
      end
    for (int i = 0; i < N0; i++) out_q0.push_back(tx_order0[i]);
    for (int i = 0; i < N0; i++) begin
      @(negedge clk);
      if (i == N0 - 1) chk("in_stall_before_last", int'(in_stall0), 0);
      in_push0 = 1'b1;
      in_real0 = 16'(f * 100 + i);
      in_imag0 = 16'($urandom);
      in_qa.push_back(i);
      in_qd.push_back({in_real0, in_imag0});
    end
    @(negedge clk);
    chk("in_stall_after_last", int'(in_stall0), 1);
    repeat (extra) @(negedge clk);
    in_push0 = 1'b0;
  endtask

  task automatic wait_done0(input string nm);
    int t;
    t = 0;
    while (!fd_0 && t < 300) begin @(negedge clk); #1; t++; end
    if (!fd_0) flag(nm);
    @(negedge clk);
    chk("bf_queue_empty", bf_qa.size(), 0);
    chk("tx_queue_empty", out_q0.size(), 0);
    chk("in_queue_empty", in_qa.size(), 0);
  endtask

  task automatic stall0();
    int t;
    t = 0;
    while (n_push0 < 5 && t < 300) begin @(negedge clk); #1; t++; end
    if (n_push0 < 5) flag("stall_wait_timeout");
    out_stall0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_stall0 = 1'b0;
  endtask

  initial begin
    int t;
    vecs[0] = '{0, 0, 0, 8, 0};   vecs[1] = '{0, 7, 7, 15, 7};
    vecs[2] = '{1, 0, 0, 4, 0};   vecs[3] = '{1, 5, 9, 13, 2};
    vecs[4] = '{2, 3, 5, 7, 4};   vecs[5] = '{2, 6, 12, 14, 0};
    vecs[6] = '{3, 5, 10, 11, 0}; vecs[7] = '{3, 7, 14, 15, 0};
    tx_order0 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    tx_order1 = '{0, 4, 2, 6, 1, 5, 3, 7};
    in_push0 = 0; in_real0 = 0; in_imag0 = 0; out_stall0 = 0;
    in_push1 = 0; in_real1 = 0; in_imag1 = 0; out_stall1 = 0;

    #1 reset = 1'b1;
    #2;
    chk("rst_in_stall", int'(in_stall0), 1);
    chk("rst_we1", int'(we1_0), 0);
    chk("rst_we2", int'(we2_0), 0);
    chk("rst_out_push", int'(op_0), 0);
    chk("rst_frame_done", int'(fd_0), 0);
    chk("rst_read_addr1", int'(ra1_0), 0);
    chk("rst_wdata", int'(wd_0), 0);
    chk("rst_in_stall_8pt", int'(in_stall1), 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("in_stall_after_release", int'(in_stall0), 0);
    chk("in_stall_after_release_8pt", int'(in_stall1), 0);

    // 8-point, BF_LAT=2 instance
    for (int i = 0; i < N1; i++) out_q1.push_back(tx_order1[i]);
    for (int i = 0; i < N1; i++) begin
      @(negedge clk);
      in_push1 = 1'b1; in_real1 = 16'(i); in_imag1 = 16'(i * 7);
    end
    @(negedge clk);
    in_push1 = 1'b0;
    t = 0;
    while (!fd_1 && t < 200) begin @(negedge clk); #1; t++; end
    if (!fd_1) flag("done_timeout_8pt");
    chk("compute_len_8pt", first_k1, 3 * (N1 / 2 + LAT1) + 1);
    for (int b = 0; b < N1 / 2; b++) begin
      chk("stage0_a_8pt", rd_a1[b + 1], b);
      chk("stage0_b_8pt", rd_b1[b + 1], b + 4);
    end
    chk("tx_queue_empty_8pt", out_q1.size(), 0);

    // Frame 1: back-to-back input, pushes ignored while stalled
    n_push0 = 0;
    send0(1, 3);
    wait_done0("done_timeout_f1");
    chk("compute_len", first_k0, L0 * (N0 / 2 + LAT0) + 1);
    for (int i = 0; i < 8; i++) begin
      int sl;
      sl = vecs[i].s * (N0 / 2 + LAT0) + vecs[i].b + 1;
      chk("vec_read_a", rd_a0[sl], vecs[i].a);
      chk("vec_read_b", rd_b0[sl], vecs[i].bb);
      chk("vec_twiddle", rd_w0[sl], vecs[i].w);
      chk("vec_write_en", wr_e0[sl + LAT0], 1);
      chk("vec_write_a", wr_a0[sl + LAT0], vecs[i].a);
      chk("vec_write_b", wr_b0[sl + LAT0], vecs[i].bb);
    end

    // Frame 2: downstream stall after the 5th output
    n_push0 = 0;
    fork
      send0(2, 0);
      stall0();
    join
    wait_done0("done_timeout_f2");
    chk("stall_gap", push_cyc0[5] - push_cyc0[4], 4);
    chk("addr_after_stall", push_addr0[5], 10);
    chk("push_count_f2", n_push0, N0);

    // Frame 3: reset during compute stage 1
    n_push0 = 0;
    send0(3, 0);
    t = 0;
    while (k0 != 18 && t < 200) begin @(negedge clk); #1; t++; end
    chk("we1_before_reset", int'(we1_0), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_we1", int'(we1_0), 0);
    chk("abort_we2", int'(we2_0), 0);
    chk("abort_write_back", int'(wb_0), 0);
    chk("abort_out_push", int'(op_0), 0);
    chk("abort_in_stall", int'(in_stall0), 1);
    in_qa.delete(); in_qd.delete(); bf_qa.delete(); bf_qb.delete(); out_q0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("in_stall_after_abort", int'(in_stall0), 0);

    // Frame 4: fresh frame after abort
    n_push0 = 0;
    send0(4, 0);
    wait_done0("done_timeout_f4");
    chk("push_count_f4", n_push0, N0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
